// File: rtl/expr_lane_pipe_if.sv
// ============================================================================
// Module   : expr_lane_pipe_if
// Brief    : Valid/ready operand and result bundle for expr_lane_pipe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface expr_lane_pipe_if #(
    parameter int W     = 6,
    parameter int LANES = 4,
    parameter int CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*W-1:0]   a;
    logic [LANES*W-1:0]   b;
    logic [2:0]           op;
    logic                 sgn;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*W-1:0]   y;
    logic [LANES-1:0]     ovf;
    logic [CNT_W-1:0]     ovf_count;

    modport master (
        output in_valid, a, b, op, sgn, out_ready,
        input  in_ready, out_valid, y, ovf, ovf_count
    );

    modport slave (
        input  in_valid, a, b, op, sgn, out_ready,
        output in_ready, out_valid, y, ovf, ovf_count
    );
endinterface

`default_nettype wire

// File: rtl/expr_lane_pipe.sv
// ============================================================================
// Module   : expr_lane_pipe
// Brief    : Multi-lane mixed-signedness expression evaluator behind a
//            valid/ready pipeline with a saturating overflow counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module expr_lane_pipe #(
    parameter int W      = 6,
    parameter int LANES  = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    expr_lane_pipe_if.slave  bus
);
    localparam int DW = LANES * W;

    // Returns {ovf, result} for one lane.
    function automatic logic [W:0] eval_lane(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic [2:0]   op,
        input logic         sgn
    );
        logic [W:0]     ax, bx, sum, dif;
        logic [2*W-1:0] ea, eb, prod;
        logic [W-1:0]   res;
        logic           of;
        logic           lt;
        ax   = {sgn & a[W-1], a};
        bx   = {sgn & b[W-1], b};
        sum  = ax + bx;
        dif  = ax - bx;
        ea   = {{W{sgn & a[W-1]}}, a};
        eb   = {{W{sgn & b[W-1]}}, b};
        prod = ea * eb;
        lt   = sgn ? ($signed(a) < $signed(b)) : (a < b);
        res  = '0;
        of   = 1'b0;
        case (op)
            3'd0: begin
                res = sum[W-1:0];
                of  = sgn ? (sum[W] ^ sum[W-1]) : sum[W];
            end
            3'd1: begin
                res = dif[W-1:0];
                of  = sgn ? (dif[W] ^ dif[W-1]) : dif[W];
            end
            3'd2: begin
                res = prod[W-1:0];
                // Signed fit means the top W+1 product bits are all copies of the sign.
                of  = sgn ? !((&prod[2*W-1:W-1]) || !(|prod[2*W-1:W-1]))
                          : (|prod[2*W-1:W]);
            end
            3'd3: begin
                if ({1'b0, b} >= (W+1)'(W)) begin
                    res = sgn ? {W{a[W-1]}} : '0;
                end else if (sgn) begin
                    res = $signed(a) >>> b;
                end else begin
                    res = a >> b;
                end
            end
            3'd4: res = {{(W-1){1'b0}}, lt};
            3'd5: res = {{(W-1){1'b0}}, (|a) && (|b)};
            3'd6: res = {{(W-1){1'b0}}, ~^a};
            3'd7: res = (|a) ? b : ~b;
            default: res = '0;
        endcase
        return {of, res};
    endfunction

    logic [DW-1:0]     w_y;
    logic [LANES-1:0]  w_ovf;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [W:0] w_res;
        always_comb w_res = eval_lane(bus.a[(LANES-1-l)*W +: W],
                                      bus.b[(LANES-1-l)*W +: W],
                                      bus.op, bus.sgn);
        assign w_y[(LANES-1-l)*W +: W] = w_res[W-1:0];
        assign w_ovf[LANES-1-l]        = w_res[W];
    end

    logic [STAGES-1:0] r_vld;
    logic [DW-1:0]     r_y   [STAGES];
    logic [LANES-1:0]  r_ovf [STAGES];
    logic [CNT_W-1:0]  r_cnt;
    logic [STAGES-1:0] w_load;

    // A stage may load when empty or when its occupant leaves this cycle.
    always_comb begin : p_load
        logic w_free;
        w_free = bus.out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_load[i] = !r_vld[i] || w_free;
            w_free    = w_load[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
            r_cnt <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_y[i]   <= '0;
                r_ovf[i] <= '0;
            end
        end else begin
            if (w_load[0]) begin
                r_vld[0] <= bus.in_valid;
                r_y[0]   <= w_y;
                r_ovf[0] <= w_ovf;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (w_load[i]) begin
                    r_vld[i] <= r_vld[i-1];
                    r_y[i]   <= r_y[i-1];
                    r_ovf[i] <= r_ovf[i-1];
                end
            end
            if (r_vld[STAGES-1] && bus.out_ready && (|r_ovf[STAGES-1]) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = w_load[0];
    assign bus.out_valid = r_vld[STAGES-1];
    assign bus.y         = r_y[STAGES-1];
    assign bus.ovf       = r_ovf[STAGES-1];
    assign bus.ovf_count = r_cnt;

endmodule

`default_nettype wire
